receptor_ascii: RTL and testbench

Serial receiver for 7-bit ASCII messages: the stage directly downstream of the ASCII transmitter on the serial line. It deserializes 7O1 frames at a fixed baud rate and stores up to 8 characters in a message buffer. A message closes on the terminator `#` (7'h23) or on the 8th character. It then presents the whole buffer in parallel with a one-cycle `pronto` pulse for the consuming logic.

---
 rtl/receptor_ascii.sv | 279 +++++++++++++++++++++++++++
 tb/tb_receptor_ascii.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/receptor_ascii.sv
// -----------------------------------------------------------------------------
// receptor_ascii
//
// Serial receiver for 7-bit ASCII messages using 7O1 frames: one start bit,
// seven data bits LSB first, one odd-parity bit and one stop bit, at a fixed
// CICLOS_BIT clocks per bit. Received characters are collected into an
// 8-slot message buffer. A message closes on TERMINADOR (which is stored) or
// when the 8th character arrives. The whole buffer is then presented in
// parallel together with a one-cycle pronto pulse.
//
// Ports:
//   clock           system clock
//   reset           synchronous, active-high; clears every register
//   entrada_serial  serial line, idle high, asynchronous to clock
//   dados_ascii     message buffer; character i on bits [7i+6:7i], i=0 first
//   num_caracteres  characters stored in the current message (0..8)
//   pronto          one-cycle pulse when a message closes
//   erro            sticky parity/framing error flag for the current message
//   db_estado       current FSM state code, for debug
// -----------------------------------------------------------------------------
module receptor_ascii #(
    parameter int         CICLOS_BIT = 434,
    parameter logic [6:0] TERMINADOR = 7'h23
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrada_serial,
    output logic [55:0] dados_ascii,
    output logic [3:0]  num_caracteres,
    output logic        pronto,
    output logic        erro,
    output logic [3:0]  db_estado
);

    localparam int CNT_W = $clog2(CICLOS_BIT);
    // Last cycle of a full bit period and of the half period to the start-bit centre.
    localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(CICLOS_BIT - 1);
    localparam logic [CNT_W-1:0] MEIO_BIT = CNT_W'(CICLOS_BIT / 2 - 1);

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        ESPERA   = 4'd1,
        START    = 4'd2,
        DADOS    = 4'd3,
        PARIDADE = 4'd4,
        STOP     = 4'd5,
        ARMAZENA = 4'd6,
        FIM      = 4'd7
    } estado_t;

    // True when data plus parity bit hold an odd number of ones.
    function automatic logic paridade_ok(input logic [6:0] dado, input logic bit_par);
        return ^{dado, bit_par};
    endfunction

    logic             sync1_r;
    logic             sync2_r;
    logic             rx_s;
    estado_t          estado_r;
    estado_t          estado_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [6:0]       shift_r;
    logic             erro_quadro_r;
    logic             msg_nova_r;
    logic [55:0]      dados_r;
    logic [3:0]       num_r;
    logic             erro_r;
    logic             pronto_r;
    logic             fim_bit_s;
    logic             meio_bit_s;
    logic [2:0]       slot_s;
    logic [3:0]       num_apos_s;
    logic             fecha_s;
    logic [55:0]      dados_prox_s;
    logic             erro_prox_s;

    assign rx_s = sync2_r;

    // Two-flop synchronizer for the asynchronous serial line; resets to idle high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= entrada_serial;
            sync2_r <= sync1_r;
        end
    end

    // Bit-period timing flags.
    always_comb begin
        fim_bit_s  = (cnt_r == FIM_BIT);
        meio_bit_s = (cnt_r == MEIO_BIT);
    end

    // Storage decisions for the character being written in ARMAZENA.
    // The first character after a close (or reset) starts a fresh buffer.
    always_comb begin
        slot_s       = 3'd0;
        num_apos_s   = 4'd0;
        dados_prox_s = 56'd0;
        erro_prox_s  = 1'b0;
        if (msg_nova_r) begin
            slot_s       = 3'd0;
            num_apos_s   = 4'd1;
            dados_prox_s = 56'd0;
            erro_prox_s  = erro_quadro_r;
        end else begin
            slot_s       = num_r[2:0];
            num_apos_s   = num_r + 4'd1;
            dados_prox_s = dados_r;
            erro_prox_s  = erro_r | erro_quadro_r;
        end
        dados_prox_s[slot_s * 6'd7 +: 7] = shift_r;
        fecha_s = (shift_r == TERMINADOR) || (num_apos_s == 4'd8);
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado_r <= INICIAL;
        end else begin
            estado_r <= estado_next_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        estado_next_s = estado_r;
        case (estado_r)
            INICIAL: begin
                estado_next_s = ESPERA;
            end
            ESPERA: begin
                if (rx_s == 1'b0) begin
                    estado_next_s = START;
                end else begin
                    estado_next_s = ESPERA;
                end
            end
            START: begin
                // A line already back high at mid start bit is a glitch.
                if (meio_bit_s) begin
                    if (rx_s == 1'b1) begin
                        estado_next_s = ESPERA;
                    end else begin
                        estado_next_s = DADOS;
                    end
                end else begin
                    estado_next_s = START;
                end
            end
            DADOS: begin
                if (fim_bit_s && (bit_cnt_r == 3'd6)) begin
                    estado_next_s = PARIDADE;
                end else begin
                    estado_next_s = DADOS;
                end
            end
            PARIDADE: begin
                if (fim_bit_s) begin
                    estado_next_s = STOP;
                end else begin
                    estado_next_s = PARIDADE;
                end
            end
            STOP: begin
                if (fim_bit_s) begin
                    estado_next_s = ARMAZENA;
                end else begin
                    estado_next_s = STOP;
                end
            end
            ARMAZENA: begin
                if (fecha_s) begin
                    estado_next_s = FIM;
                end else begin
                    estado_next_s = ESPERA;
                end
            end
            FIM: begin
                estado_next_s = ESPERA;
            end
            default: begin
                estado_next_s = INICIAL;
            end
        endcase
    end

    // Bit timing, data deserialization and per-frame error capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r         <= '0;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 7'd0;
            erro_quadro_r <= 1'b0;
        end else begin
            case (estado_r)
                ESPERA: begin
                    cnt_r         <= '0;
                    bit_cnt_r     <= 3'd0;
                    erro_quadro_r <= 1'b0;
                end
                START: begin
                    if (meio_bit_s) begin
                        cnt_r <= '0;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DADOS: begin
                    // Shift in from the top so the first bit ends at bit 0.
                    if (fim_bit_s) begin
                        cnt_r     <= '0;
                        shift_r   <= {rx_s, shift_r[6:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                PARIDADE: begin
                    if (fim_bit_s) begin
                        cnt_r <= '0;
                        if (!paridade_ok(shift_r, rx_s)) begin
                            erro_quadro_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                STOP: begin
                    if (fim_bit_s) begin
                        cnt_r <= '0;
                        if (rx_s == 1'b0) begin
                            erro_quadro_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    cnt_r <= '0;
                end
            endcase
        end
    end

    // Message buffer, character count and sticky error; change only in ARMAZENA.
    always_ff @(posedge clock) begin
        if (reset) begin
            dados_r    <= 56'd0;
            num_r      <= 4'd0;
            erro_r     <= 1'b0;
            msg_nova_r <= 1'b1;
        end else if (estado_r == ARMAZENA) begin
            dados_r    <= dados_prox_s;
            num_r      <= num_apos_s;
            erro_r     <= erro_prox_s;
            msg_nova_r <= fecha_s;
        end
    end

    // Registered pronto: high exactly while the FSM sits in FIM.
    always_ff @(posedge clock) begin
        if (reset) begin
            pronto_r <= 1'b0;
        end else begin
            pronto_r <= (estado_next_s == FIM);
        end
    end

    assign dados_ascii    = dados_r;
    assign num_caracteres = num_r;
    assign erro           = erro_r;
    assign pronto         = pronto_r;
    assign db_estado      = estado_r;

endmodule

// File: tb/tb_receptor_ascii.sv
`timescale 1ns/1ps
module tb_receptor_ascii;

    // Shortened bit period keeps the run short; glitch length keeps the
    // 150/434 ratio of the default rate, i.e. well below half a bit.
    localparam int CB     = 64;
    localparam int HALF   = CB / 2;
    localparam int GLITCH = (CB * 150) / 434;

    logic        clock = 1'b0;
    logic        reset;
    logic        entrada_serial;
    logic [55:0] dados_ascii;
    logic [3:0]  num_caracteres;
    logic        pronto;
    logic        erro;
    logic [3:0]  db_estado;

    receptor_ascii #(.CICLOS_BIT(CB), .TERMINADOR(7'h23)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .dados_ascii    (dados_ascii),
        .num_caracteres (num_caracteres),
        .pronto         (pronto),
        .erro           (erro),
        .db_estado      (db_estado)
    );

    always #10 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc = cyc + 1;

    // pronto monitor: counts high cycles and snapshots outputs at the pulse.
    int         pronto_cnt = 0;
    int         pronto_cyc = 0;
    logic [3:0] snap_num;
    logic       snap_erro;
    always @(negedge clock) begin
        if (pronto === 1'b1) begin
            pronto_cnt = pronto_cnt + 1;
            pronto_cyc = cyc;
            snap_num   = num_caracteres;
            snap_erro  = erro;
        end
    end

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model of the message buffer.
    logic [6:0] mbuf [8];
    int         mn      = 0;
    logic       merr    = 1'b0;
    logic       mnew    = 1'b1;
    int         mcloses = 0;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mbuf[i] = 7'd0;
        mn   = 0;
        merr = 1'b0;
        mnew = 1'b1;
    endtask

    function automatic logic [55:0] model_pack();
        logic [55:0] v;
        v = 56'd0;
        for (int i = 0; i < 8; i++) v = v | ({49'd0, mbuf[i]} << (7 * i));
        return v;
    endfunction

    // kind: 0 clean, 1 inverted parity, 2 stop bit sent as 0.
    task automatic send_frame(input logic [6:0] c, input int kind);
        int         n0;
        logic       p;
        logic [9:0] bits;
        logic       close;
        p = ($countones(c) % 2 == 0) ? 1'b1 : 1'b0;
        if (kind == 1) p = ~p;
        bits = {(kind == 2) ? 1'b0 : 1'b1, p, c, 1'b0};
        @(negedge clock);
        n0 = cyc;
        for (int i = 0; i < 10; i++) begin
            entrada_serial = bits[i];
            repeat (CB) @(negedge clock);
        end
        entrada_serial = 1'b1;
        if (kind == 2) repeat (2 * CB) @(negedge clock);

        if (mnew) model_reset();
        mbuf[mn] = c;
        mn       = mn + 1;
        merr     = merr | (kind != 0);
        close    = (c == 7'h23) || (mn == 8);
        mnew     = close;
        if (close) mcloses++;

        chk("pronto_count", pronto_cnt, mcloses);
        if (close) begin
            // Stop bit centre on the pin, 2 sync flops, then 2 cycles to FIM.
            chk("pronto_time", pronto_cyc, n0 + 9 * CB + HALF + 4);
            chk("num_at_pronto", snap_num, mn);
            chk("erro_at_pronto", snap_erro, merr);
        end
        chk("dados_ascii", dados_ascii, model_pack());
        chk("num_caracteres", num_caracteres, mn);
        chk("erro", erro, merr);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_frame(7'(s[i]), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [55:0] d0;
        logic [3:0]  nn0;
        logic        e0;
        int          p0;
        int          max_st;
        int          len;
        logic [6:0]  c;
        int          r;

        reset          = 1'b1;
        entrada_serial = 1'b1;
        model_reset();
        repeat (100) @(negedge clock);
        chk("rst_dados", dados_ascii, 56'd0);
        chk("rst_num", num_caracteres, 4'd0);
        chk("rst_pronto", pronto, 1'b0);
        chk("rst_erro", erro, 1'b0);
        chk("rst_estado", db_estado, 4'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("estado_espera", db_estado, 4'd1);
        repeat (CB) @(negedge clock);

        // Full 8-character message closed by '#'.
        send_str("147,297#");
        // Short message.
        send_str("12#");
        chk("upper_zero", dados_ascii[55:21], 35'd0);
        // Parity error on the first character; error persists to the close.
        send_frame(7'h35, 1);
        send_frame(7'h23, 0);
        chk("erro_held", erro, 1'b1);
        // Nine characters: closes on the 8th, 'I' starts a new message.
        send_str("ABCDEFGHI");
        chk("slot0_I", dados_ascii[6:0], 7'h49);

        // Short low glitch in ESPERA must be rejected as a false start.
        repeat (CB) @(negedge clock);
        d0 = dados_ascii; nn0 = num_caracteres; e0 = erro; p0 = pronto_cnt;
        max_st = 0;
        for (int i = 0; i < 2 * CB; i++) begin
            entrada_serial = (i < GLITCH) ? 1'b0 : 1'b1;
            @(negedge clock);
            if (int'(db_estado) > max_st) max_st = int'(db_estado);
        end
        chk("glitch_max_state", max_st, 2);
        chk("glitch_back_espera", db_estado, 4'd1);
        chk("glitch_dados", dados_ascii, d0);
        chk("glitch_num", num_caracteres, nn0);
        chk("glitch_erro", erro, e0);
        chk("glitch_pronto", pronto_cnt, p0);

        // Reset in the middle of a frame, during DADOS.
        @(negedge clock);
        entrada_serial = 1'b0;
        repeat (CB) @(negedge clock);
        entrada_serial = 1'b1;
        repeat (CB) @(negedge clock);
        chk("mid_estado_dados", db_estado, 4'd3);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_dados", dados_ascii, 56'd0);
        chk("mid_rst_num", num_caracteres, 4'd0);
        chk("mid_rst_erro", erro, 1'b0);
        chk("mid_rst_pronto", pronto, 1'b0);
        chk("mid_rst_estado", db_estado, 4'd0);
        model_reset();
        @(negedge clock);
        chk("mid_rst_espera", db_estado, 4'd1);
        repeat (2 * CB) @(negedge clock);
        send_str("7#");

        // Random messages with occasional parity or stop-bit errors.
        for (int m = 0; m < 5; m++) begin
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                c = 7'($urandom_range(32, 126));
                if (c == 7'h23) c = 7'h24;
                if ((k == len - 1) && ($urandom_range(0, 1) == 1)) c = 7'h23;
                r = $urandom_range(0, 5);
                send_frame(c, (r == 4) ? 1 : ((r == 5) ? 2 : 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
